// File: rtl/loop_index_vector_if.sv
// Handshake bundle for loop_index_vector: run configuration in, lane-index beats out.
// The block itself binds to the slave modport; its feeder/consumer side uses master.
interface loop_index_vector_if #(
    parameter int LANES     = 5,
    parameter int WIDTH     = 5,
    parameter int CNT_WIDTH = 16
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [WIDTH-1:0]     cfg_base;
    logic [WIDTH-1:0]     cfg_stride;
    logic [CNT_WIDTH-1:0] cfg_beats;
    logic [WIDTH-1:0]     O [LANES-1:0];
    logic                 O_valid;
    logic                 O_ready;
    logic                 O_last;
    logic                 done;
    logic                 busy;

    modport master (
        output cfg_valid, cfg_base, cfg_stride, cfg_beats, O_ready,
        input  cfg_ready, O, O_valid, O_last, done, busy
    );

    modport slave (
        input  cfg_valid, cfg_base, cfg_stride, cfg_beats, O_ready,
        output cfg_ready, O, O_valid, O_last, done, busy
    );
endinterface

// File: rtl/loop_index_vector.sv
// Streams LANES-wide vectors of loop indices: lane i of beat k = base + (k*LANES + i)*stride,
// all arithmetic wrapping mod 2^WIDTH. Every output is registered.
module loop_index_vector #(
    parameter int LANES     = 5,
    parameter int WIDTH     = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    loop_index_vector_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nx;
    logic [WIDTH-1:0]     cur_r;
    logic [WIDTH-1:0]     cur_nx;
    logic [WIDTH-1:0]     stride_r;
    logic [WIDTH-1:0]     stride_nx;
    logic [CNT_WIDTH-1:0] remaining_r;
    logic [CNT_WIDTH-1:0] remaining_nx;
    logic [WIDTH-1:0]     o_r  [LANES-1:0];
    logic [WIDTH-1:0]     o_nx [LANES-1:0];
    logic                 o_valid_r;
    logic                 o_valid_nx;
    logic                 o_last_r;
    logic                 o_last_nx;
    logic                 done_r;
    logic                 done_nx;
    logic                 cfg_ready_r;
    logic                 busy_r;
    logic                 cfg_fire_s;
    logic                 beat_fire_s;

    // base + lane*stride; the product is taken mod 2^WIDTH, which is all the sum keeps anyway
    function automatic logic [WIDTH-1:0] lane_index(
        input logic [WIDTH-1:0] base,
        input logic [WIDTH-1:0] stride,
        input int               lane
    );
        logic [WIDTH-1:0] offset;
        offset = WIDTH'(lane) * stride;
        return base + offset;
    endfunction

    assign cfg_fire_s  = bus.cfg_valid & cfg_ready_r & (state_r == ST_IDLE);
    assign beat_fire_s = o_valid_r & bus.O_ready;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state, run bookkeeping and next values of the registered outputs
    always_comb begin
        state_nx     = state_r;
        cur_nx       = cur_r;
        stride_nx    = stride_r;
        remaining_nx = remaining_r;
        o_valid_nx   = 1'b0;
        o_last_nx    = 1'b0;
        done_nx      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_fire_s) begin
                    cur_nx       = bus.cfg_base;
                    stride_nx    = bus.cfg_stride;
                    remaining_nx = bus.cfg_beats;
                    if (bus.cfg_beats != {CNT_WIDTH{1'b0}}) begin
                        state_nx   = ST_RUN;
                        o_valid_nx = 1'b1;
                        o_last_nx  = (bus.cfg_beats == CNT_WIDTH'(1));
                    end else begin
                        done_nx = 1'b1;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (beat_fire_s) begin
                    if (remaining_r == CNT_WIDTH'(1)) begin
                        state_nx     = ST_IDLE;
                        remaining_nx = {CNT_WIDTH{1'b0}};
                        done_nx      = 1'b1;
                    end else begin
                        // lane 0 of the next beat sits LANES strides past lane 0 of this one
                        cur_nx       = lane_index(cur_r, stride_r, LANES);
                        remaining_nx = remaining_r - CNT_WIDTH'(1);
                        o_valid_nx   = 1'b1;
                        o_last_nx    = (remaining_r == CNT_WIDTH'(2));
                    end
                end else begin
                    o_valid_nx = o_valid_r;
                    o_last_nx  = o_last_r;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Lane vector for the next cycle; zero whenever no beat is presented
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            o_nx[i] = o_valid_nx ? lane_index(cur_nx, stride_nx, i) : {WIDTH{1'b0}};
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur_r       <= {WIDTH{1'b0}};
            stride_r    <= {WIDTH{1'b0}};
            remaining_r <= {CNT_WIDTH{1'b0}};
            o_valid_r   <= 1'b0;
            o_last_r    <= 1'b0;
            done_r      <= 1'b0;
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                o_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            cur_r       <= cur_nx;
            stride_r    <= stride_nx;
            remaining_r <= remaining_nx;
            o_valid_r   <= o_valid_nx;
            o_last_r    <= o_last_nx;
            done_r      <= done_nx;
            cfg_ready_r <= (state_nx == ST_IDLE);
            busy_r      <= (state_nx == ST_RUN);
            for (int i = 0; i < LANES; i++) begin
                o_r[i] <= o_nx[i];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign bus.O[g] = o_r[g];
    end

    assign bus.O_valid   = o_valid_r;
    assign bus.O_last    = o_last_r;
    assign bus.done      = done_r;
    assign bus.cfg_ready = cfg_ready_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_loop_index_vector.sv
// Bench for loop_index_vector: directed runs from the plan plus random traffic, all checked
// against a run-level model that derives each lane as base + (k*LANES + i)*stride mod 2^WIDTH.
module tb_loop_index_vector;

    localparam int LANES     = 5;
    localparam int WIDTH     = 5;
    localparam int CNT_WIDTH = 16;
    localparam int MODULUS   = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    loop_index_vector_if #(.LANES(LANES), .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    loop_index_vector #(.LANES(LANES), .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Run-level model: is a run in flight, which beat is shown, and its programming
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_rdy    = 1'b0;
    int m_k      = 0;
    int m_beats  = 0;
    int m_base   = 0;
    int m_stride = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [LANES*WIDTH-1:0] packed_o();
        logic [LANES*WIDTH-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            v[i*WIDTH +: WIDTH] = bus.O[i];
        end
        return v;
    endfunction

    function automatic logic [LANES*WIDTH-1:0] model_lanes();
        logic [LANES*WIDTH-1:0] v;
        v = '0;
        if (m_active) begin
            for (int i = 0; i < LANES; i++) begin
                v[i*WIDTH +: WIDTH] = WIDTH'((m_base + (m_k * LANES + i) * m_stride) % MODULUS);
            end
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT just sampled
    task automatic model_edge();
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_rdy    = 1'b0;
            m_k      = 0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                if (bus.O_ready) begin
                    m_k++;
                    if (m_k == m_beats) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (bus.cfg_valid && m_rdy) begin
                m_base   = int'(bus.cfg_base);
                m_stride = int'(bus.cfg_stride);
                m_beats  = int'(bus.cfg_beats);
                m_k      = 0;
                if (m_beats == 0) m_done = 1'b1;
                else m_active = 1'b1;
            end
            m_rdy = !m_active;
        end
    endtask

    task automatic check_all();
        check_eq("O_valid",   64'(bus.O_valid),   64'(m_active));
        check_eq("O_last",    64'(bus.O_last),    64'(m_active && (m_k == m_beats - 1)));
        check_eq("busy",      64'(bus.busy),      64'(m_active));
        check_eq("done",      64'(bus.done),      64'(m_done));
        check_eq("cfg_ready", 64'(bus.cfg_ready), 64'(m_rdy));
        check_eq("O_lanes",   64'(packed_o()),    64'(model_lanes()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_cfg(input int base, input int stride, input int beats);
        bus.cfg_valid  = 1'b1;
        bus.cfg_base   = WIDTH'(base);
        bus.cfg_stride = WIDTH'(stride);
        bus.cfg_beats  = CNT_WIDTH'(beats);
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_base   = '0;
        bus.cfg_stride = '0;
        bus.cfg_beats  = '0;
        bus.O_ready    = 1'b1;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single beat, unit stride
        run_cfg(0, 1, 1);
        check_eq("single_b0", 64'(packed_o()), 64'({5'd4, 5'd3, 5'd2, 5'd1, 5'd0}));
        tick();

        // Wrap-around
        run_cfg(30, 7, 2);
        check_eq("wrap_b0", 64'(packed_o()), 64'({5'd26, 5'd19, 5'd12, 5'd5, 5'd30}));
        tick();
        check_eq("wrap_b1", 64'(packed_o()), 64'({5'd29, 5'd22, 5'd15, 5'd8, 5'd1}));
        tick();

        // Backpressure on beat 1
        run_cfg(3, 2, 3);
        tick();
        bus.O_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check_eq("hold_b1", 64'(packed_o()), 64'({5'd21, 5'd19, 5'd17, 5'd15, 5'd13}));
        bus.O_ready = 1'b1;
        tick();
        check_eq("bp_b2", 64'(packed_o()), 64'({5'd31, 5'd29, 5'd27, 5'd25, 5'd23}));
        tick();

        // Empty run
        run_cfg(5, 3, 0);
        tick();

        // Config offered throughout a 4-beat run; taken in the done cycle
        run_cfg(1, 1, 4);
        bus.cfg_valid  = 1'b1;
        bus.cfg_base   = WIDTH'(9);
        bus.cfg_stride = WIDTH'(2);
        bus.cfg_beats  = CNT_WIDTH'(2);
        for (int c = 0; c < 5; c++) tick();
        bus.cfg_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();

        // Reset while beat 2 of 4 is shown
        run_cfg(2, 3, 4);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tick();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 299) == 0);
            bus.cfg_valid  = ($urandom_range(0, 2) == 0);
            bus.cfg_base   = WIDTH'($urandom);
            bus.cfg_stride = WIDTH'($urandom);
            bus.cfg_beats  = CNT_WIDTH'($urandom_range(0, 6));
            bus.O_ready    = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/loop_index_vector.md
Name: loop_index_vector

Overview:
- Parametrised successor to the fixed constant-index array generator: emits a LANES-wide vector of WIDTH-bit loop indices per beat instead of a hard-wired O[i]=i.
- Lane i of beat k = base + (k*LANES + i)*stride, mod 2^WIDTH.
- Programmed per run with base, stride and beat count; streams beats over a valid/ready handshake.
- Sits between loop-control logic and unrolled datapath lanes that need per-lane iteration indices.

Parameters:
LANES, 5, number of output lanes (>=1)
WIDTH, 5, bits per lane index (>=1); all index arithmetic is mod 2^WIDTH
CNT_WIDTH, 16, width of beat-count field

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  synchronous, active-high reset
cfg_valid  input  1  run configuration offered
cfg_ready  output  1  block accepts configuration (IDLE only)
cfg_base  input  WIDTH  index of lane 0, beat 0
cfg_stride  input  WIDTH  increment between adjacent lanes
cfg_beats  input  CNT_WIDTH  number of beats in run; 0 = empty run
O  output  [WIDTH-1:0] x LANES (unpacked array O[LANES-1:0])  lane indices of current beat
O_valid  output  1  O holds a valid beat
O_ready  input  1  consumer accepts beat
O_last  output  1  current beat is final beat of run (qualified by O_valid)
done  output  1  one-cycle pulse after run completes
busy  output  1  high in RUN

Behaviour:
- Reset (RESET high at a clock edge): state IDLE; O all lanes 0; O_valid, O_last, done, busy 0; cfg_ready 0 while RESET is high, 1 from the first cycle after.
- RESET mid-run aborts immediately: no further beats and no done pulse.
- States: IDLE, RUN.
- IDLE:
  - cfg_ready=1; O_valid=0 and O=0.
  - Config accepted on a cycle with cfg_valid & cfg_ready. Latch stride, remaining = cfg_beats, cur = cfg_base.
  - cfg_beats != 0: go to RUN. Next cycle O_valid=1 with beat 0 (one-cycle latency). O_last = (cfg_beats==1).
  - cfg_beats == 0: stay IDLE. done=1 next cycle; O_valid is never asserted.
- RUN:
  - cfg_ready=0 and busy=1; cfg_valid is ignored.
  - O[i] = cur + i*stride mod 2^WIDTH. O is registered: no combinational path from cfg_* or O_ready to O or O_valid.
  - While O_valid & !O_ready: O, O_valid and O_last hold stable.
  - Handshake (O_valid & O_ready), not last beat: next cycle cur += LANES*stride mod 2^WIDTH, remaining -= 1, O updates, O_valid stays 1. No bubbles between beats.
  - Handshake on the last beat: next cycle state IDLE, O_valid=0, O=0, O_last=0, done=1 for exactly one cycle, cfg_ready=1.
  - A new config may be accepted in that same done cycle.
- Arithmetic:
  - All lane and cur sums are truncated to WIDTH bits and wrap silently.
  - i*stride and LANES*stride are computed at ≥WIDTH bits, then truncated.
  - stride 0 gives all lanes = base on every beat.
- O_last is 1 only when O_valid=1 and remaining==1.
- done and O_valid are never high in the same cycle.

Test Plan:
- LANES=5, WIDTH=5; cfg base=0, stride=1, beats=1, O_ready=1 -> one cycle later O={O[0..4]}={0,1,2,3,4}, O_valid=1, O_last=1; next cycle O_valid=0, done=1, cfg_ready=1.
- Wrap: base=30, stride=7, beats=2, O_ready=1 -> beat0 {30,5,12,19,26} O_last=0; beat1 {1,8,15,22,29} O_last=1; then done pulse.
- Backpressure: base=3, stride=2, beats=3; O_ready low 3 cycles at beat1 -> O holds {13,15,17,19,21}, O_valid=1 throughout; beat2 {23,25,27,29,31} appears the cycle after O_ready rises.
- Empty run: beats=0 -> O_valid stays 0, busy stays 0, done=1 the cycle after acceptance, cfg_ready stays 1.
- Config during RUN: cfg_valid held high with a different base during a 4-beat run -> cfg_ready=0 and stream unaffected; second config accepted the cycle done=1, its beat 0 appears the next cycle.
- Reset mid-run: RESET high during beat 2 of 4 -> next cycle O_valid=0, O=0, busy=0, done never pulses; cfg_ready=1 the cycle after RESET drops.
